// File: rtl/core_dispatch_scoreboard_if.sv
// Dispatch/writeback bundle between the issue stage and the dispatch scoreboard.
// The issue side drives through master; the scoreboard receives through slave.
interface core_dispatch_scoreboard_if;
  logic        dispatch_a;
  logic        dispatch_b;
  logic        a_wb;
  logic        b_wb;
  logic [3:0]  a_rd;
  logic [3:0]  b_rd;
  logic [1:0]  a_unit;
  logic [1:0]  b_unit;
  logic        done_mul;
  logic        done_ldst;
  logic        done_branch;
  logic [15:0] mask_alu_a;
  logic [15:0] mask_alu_b;
  logic [15:0] mask_mul;
  logic [15:0] mask_ldst;
  logic [15:0] mask_branch;
  logic        busy_mul;
  logic        busy_ldst;
  logic        busy_branch;
  logic        sb_err;

  modport master (
    output dispatch_a, dispatch_b, a_wb, b_wb, a_rd, b_rd, a_unit, b_unit,
           done_mul, done_ldst, done_branch,
    input  mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch,
           busy_mul, busy_ldst, busy_branch, sb_err
  );

  modport slave (
    input  dispatch_a, dispatch_b, a_wb, b_wb, a_rd, b_rd, a_unit, b_unit,
           done_mul, done_ldst, done_branch,
    output mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_branch,
           busy_mul, busy_ldst, busy_branch, sb_err
  );
endinterface

// File: rtl/core_dispatch_scoreboard.sv
// Dual-slot dispatch scoreboard: per-EU pending-write masks, EU occupancy and a sticky error flag.
// Define CORE_SCOREBOARD_BYPASS_EN to hide completing writes from the masks one cycle early.
module core_dispatch_scoreboard #(
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  core_dispatch_scoreboard_if.slave  sb
);

  localparam int N_EU = 3;  // index 0 = mul, 1 = ldst, 2 = branch (unit code minus one)

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_MUL    = 2'd1,
    UNIT_LDST   = 2'd2,
    UNIT_BRANCH = 2'd3
  } unit_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] rd;
  } stage_t;

`ifdef CORE_SCOREBOARD_BYPASS_EN
  localparam int ALU_VIS = ALU_LAT - 1;  // final stage is writing back this cycle
`else
  localparam int ALU_VIS = ALU_LAT;
`endif

  // ---------------- ALU pipelines ----------------
  stage_t [ALU_LAT-1:0] pipe_a;
  stage_t [ALU_LAT-1:0] pipe_b;
  stage_t               pipe_a_in;
  stage_t               pipe_b_in;
  logic   [15:0]        alu_mask_a;
  logic   [15:0]        alu_mask_b;

  assign pipe_a_in.vld = sb.dispatch_a && sb.a_wb && (sb.a_unit == UNIT_ALU);
  assign pipe_a_in.rd  = sb.a_rd;
  assign pipe_b_in.vld = sb.dispatch_b && sb.b_wb && (sb.b_unit == UNIT_ALU);
  assign pipe_b_in.rd  = sb.b_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_a <= '0;
      pipe_b <= '0;
    end else begin
      // NOTE: non-blocking so every stage captures its predecessor's pre-edge value.
      pipe_a[0] <= pipe_a_in;
      pipe_b[0] <= pipe_b_in;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    alu_mask_a = '0;
    alu_mask_b = '0;
    for (int i = 0; i < ALU_VIS; i++) begin
      if (pipe_a[i].vld) alu_mask_a = alu_mask_a | (16'd1 << pipe_a[i].rd);
      if (pipe_b[i].vld) alu_mask_b = alu_mask_b | (16'd1 << pipe_b[i].rd);
    end
  end

  // ---------------- single-entry EUs ----------------
  logic [N_EU-1:0]       eu_vld, eu_wb, eu_done;
  logic [N_EU-1:0]       nxt_vld, nxt_wb;
  logic [N_EU-1:0]       req_a, req_b;
  logic [N_EU-1:0][3:0]  eu_rd, nxt_rd;
  logic [N_EU-1:0][15:0] eu_mask;
  logic                  err_set;
  logic                  sb_err_q;

  assign eu_done = {sb.done_branch, sb.done_ldst, sb.done_mul};

  // A completing entry frees its EU before this cycle's dispatches are considered;
  // slot A wins when both slots target the same EU.
  always_comb begin
    nxt_vld = eu_vld;
    nxt_wb  = eu_wb;
    nxt_rd  = eu_rd;
    req_a   = '0;
    req_b   = '0;
    err_set = 1'b0;
    for (int e = 0; e < N_EU; e++) begin
      req_a[e] = sb.dispatch_a && (sb.a_unit == 2'(e + 1));
      req_b[e] = sb.dispatch_b && (sb.b_unit == 2'(e + 1));
      if (eu_done[e]) begin
        if (!eu_vld[e]) err_set = 1'b1;
        nxt_vld[e] = 1'b0;
      end
      if (req_a[e]) begin
        if (nxt_vld[e]) begin
          err_set = 1'b1;
        end else begin
          nxt_vld[e] = 1'b1;
          nxt_wb[e]  = sb.a_wb;
          nxt_rd[e]  = sb.a_rd;
        end
        if (req_b[e]) err_set = 1'b1;
      end else if (req_b[e]) begin
        if (nxt_vld[e]) begin
          err_set = 1'b1;
        end else begin
          nxt_vld[e] = 1'b1;
          nxt_wb[e]  = sb.b_wb;
          nxt_rd[e]  = sb.b_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eu_vld   <= '0;
      eu_wb    <= '0;
      eu_rd    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      eu_vld   <= nxt_vld;
      eu_wb    <= nxt_wb;
      eu_rd    <= nxt_rd;
      sb_err_q <= sb_err_q | err_set;
    end
  end

  always_comb begin
    eu_mask = '0;
    for (int e = 0; e < N_EU; e++) begin
      if (eu_vld[e] && eu_wb[e]) eu_mask[e] = 16'd1 << eu_rd[e];
`ifdef CORE_SCOREBOARD_BYPASS_EN
      if (eu_done[e]) eu_mask[e] = '0;
`endif
    end
  end

  assign sb.mask_alu_a  = alu_mask_a;
  assign sb.mask_alu_b  = alu_mask_b;
  assign sb.mask_mul    = eu_mask[0];
  assign sb.mask_ldst   = eu_mask[1];
  assign sb.mask_branch = eu_mask[2];
  assign sb.busy_mul    = eu_vld[0];
  assign sb.busy_ldst   = eu_vld[1];
  assign sb.busy_branch = eu_vld[2];
  assign sb.sb_err      = sb_err_q;

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// Directed and randomized bench for core_dispatch_scoreboard (ALU_LAT=2) against a
// queue-based model of in-flight writes; honours CORE_SCOREBOARD_BYPASS_EN if defined.
module tb_core_dispatch_scoreboard;

  localparam int ALU_LAT = 2;
`ifdef CORE_SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_dispatch_scoreboard_if sb_if ();

  core_dispatch_scoreboard #(.ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  typedef struct packed {
    logic       rst;
    logic       da;
    logic       awb;
    logic [3:0] ard;
    logic [1:0] aunit;
    logic       db;
    logic       bwb;
    logic [3:0] brd;
    logic [1:0] bunit;
    logic       dm;
    logic       dl;
    logic       dbr;
  } stim_t;

  typedef struct {
    bit         slot;
    logic [3:0] rd;
    int         cyc;
  } alu_op_t;

  stim_t      s;
  alu_op_t    alu_q[$];
  int         now;
  bit         m_busy[3];
  bit         m_wb[3];
  logic [3:0] m_rd[3];
  bit         m_err;
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    rst               = s.rst;
    sb_if.dispatch_a  = s.da;
    sb_if.a_wb        = s.awb;
    sb_if.a_rd        = s.ard;
    sb_if.a_unit      = s.aunit;
    sb_if.dispatch_b  = s.db;
    sb_if.b_wb        = s.bwb;
    sb_if.b_rd        = s.brd;
    sb_if.b_unit      = s.bunit;
    sb_if.done_mul    = s.dm;
    sb_if.done_ldst   = s.dl;
    sb_if.done_branch = s.dbr;
  endtask

  function automatic bit done_of(input int e);
    return (e == 0) ? s.dm : (e == 1) ? s.dl : s.dbr;
  endfunction

  // An ALU write is pending from the cycle after dispatch for ALU_LAT cycles.
  function automatic logic [15:0] exp_alu(input bit slot);
    logic [15:0] m = '0;
    int last = BYPASS ? ALU_LAT - 1 : ALU_LAT;
    foreach (alu_q[i]) begin
      int age = now - alu_q[i].cyc;
      if (alu_q[i].slot == slot && age >= 1 && age <= last) m = m | (16'd1 << alu_q[i].rd);
    end
    return m;
  endfunction

  function automatic logic [15:0] exp_eu(input int e);
    if (!m_busy[e] || !m_wb[e]) return 16'h0000;
    if (BYPASS && done_of(e)) return 16'h0000;
    return 16'd1 << m_rd[e];
  endfunction

  task automatic settle();
    @(negedge clk);
    check("mask_alu_a",  sb_if.mask_alu_a,  exp_alu(1'b0));
    check("mask_alu_b",  sb_if.mask_alu_b,  exp_alu(1'b1));
    check("mask_mul",    sb_if.mask_mul,    exp_eu(0));
    check("mask_ldst",   sb_if.mask_ldst,   exp_eu(1));
    check("mask_branch", sb_if.mask_branch, exp_eu(2));
    check("busy_mul",    16'(sb_if.busy_mul),    16'(m_busy[0]));
    check("busy_ldst",   16'(sb_if.busy_ldst),   16'(m_busy[1]));
    check("busy_branch", 16'(sb_if.busy_branch), 16'(m_busy[2]));
    check("sb_err",      16'(sb_if.sb_err),      16'(m_err));
  endtask

  task automatic tick();
    alu_op_t keep[$];
    @(posedge clk);
    if (s.rst) begin
      alu_q.delete();
      m_busy = '{default: 1'b0};
      m_err  = 1'b0;
    end else begin
      if (s.da && s.awb && s.aunit == 2'd0) alu_q.push_back('{1'b0, s.ard, now});
      if (s.db && s.bwb && s.bunit == 2'd0) alu_q.push_back('{1'b1, s.brd, now});
      for (int e = 0; e < 3; e++) begin
        bit occupied;
        if (done_of(e)) begin
          if (m_busy[e]) m_busy[e] = 1'b0;
          else           m_err     = 1'b1;
        end
        occupied = m_busy[e];
        if (s.da && int'(s.aunit) == e + 1) begin
          if (occupied) m_err = 1'b1;
          else begin
            m_busy[e] = 1'b1; m_wb[e] = s.awb; m_rd[e] = s.ard; occupied = 1'b1;
          end
        end
        if (s.db && int'(s.bunit) == e + 1) begin
          if (occupied) m_err = 1'b1;
          else begin
            m_busy[e] = 1'b1; m_wb[e] = s.bwb; m_rd[e] = s.brd;
          end
        end
      end
    end
    now++;
    foreach (alu_q[i]) if (now - alu_q[i].cyc <= ALU_LAT) keep.push_back(alu_q[i]);
    alu_q = keep;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    now      = 0;
    m_err    = 1'b0;
    m_busy   = '{default: 1'b0};
    m_wb     = '{default: 1'b0};
    m_rd     = '{default: 4'd0};

    // Reset
    s = '0; s.rst = 1'b1; apply(); tick(); tick();
    s = '0; apply(); settle();
    check("rst_err", 16'(sb_if.sb_err), 16'h0000);
    check("rst_mask_alu_a", sb_if.mask_alu_a, 16'h0000);
    tick();

    // ALU slot A, rd=5: pending for exactly ALU_LAT cycles
    s = '0; s.da = 1; s.awb = 1; s.ard = 4'd5; s.aunit = 2'd0; apply(); settle(); tick();
    s = '0; apply(); settle();
    check("alu_c1", sb_if.mask_alu_a, 16'h0020);
    tick(); settle();
    check("alu_c2", sb_if.mask_alu_a, BYPASS ? 16'h0000 : 16'h0020);
    tick(); settle();
    check("alu_c3", sb_if.mask_alu_a, 16'h0000);
    tick();

    // Mul on slot B, rd=3, done four cycles after dispatch
    s = '0; s.db = 1; s.bwb = 1; s.brd = 4'd3; s.bunit = 2'd1; apply(); settle(); tick();
    s = '0; apply();
    repeat (3) begin
      settle();
      check("mul_pend_mask", sb_if.mask_mul, 16'h0008);
      check("mul_pend_busy", 16'(sb_if.busy_mul), 16'h0001);
      tick();
    end
    s.dm = 1; apply(); settle();
    check("mul_done_mask", sb_if.mask_mul, BYPASS ? 16'h0000 : 16'h0008);
    check("mul_done_busy", 16'(sb_if.busy_mul), 16'h0001);
    tick();
    s = '0; apply(); settle();
    check("mul_after_mask", sb_if.mask_mul, 16'h0000);
    check("mul_after_busy", 16'(sb_if.busy_mul), 16'h0000);
    tick();

    // Ldst done and re-dispatch in the same cycle
    s = '0; s.da = 1; s.awb = 1; s.ard = 4'd2; s.aunit = 2'd2; apply(); settle(); tick();
    s = '0; s.dl = 1; s.da = 1; s.awb = 1; s.ard = 4'd7; s.aunit = 2'd2; apply(); settle();
    check("ldst_old_mask", sb_if.mask_ldst, BYPASS ? 16'h0000 : 16'h0004);
    tick();
    s = '0; apply(); settle();
    check("ldst_new_busy", 16'(sb_if.busy_ldst), 16'h0001);
    check("ldst_new_mask", sb_if.mask_ldst, 16'h0080);
    check("ldst_no_err", 16'(sb_if.sb_err), 16'h0000);
    tick();
    s.dl = 1; apply(); settle(); tick();

    // Both slots to branch: slot A kept, error raised and held
    s = '0; s.da = 1; s.awb = 1; s.ard = 4'd1; s.aunit = 2'd3;
    s.db = 1; s.bwb = 1; s.brd = 4'd4; s.bunit = 2'd3; apply(); settle(); tick();
    s = '0; apply(); settle();
    check("br_mask", sb_if.mask_branch, 16'h0002);
    check("br_err", 16'(sb_if.sb_err), 16'h0001);
    tick(); settle();
    check("br_err_sticky", 16'(sb_if.sb_err), 16'h0001);
    tick();
    s.dbr = 1; apply(); settle(); tick();

    // Reset with mul rd=9 and three ALU ops in flight, then a late done_mul
    s = '0; s.da = 1; s.awb = 1; s.ard = 4'd1; s.aunit = 2'd0;
    s.db = 1; s.bwb = 1; s.brd = 4'd9; s.bunit = 2'd1; apply(); settle(); tick();
    s = '0; s.da = 1; s.awb = 1; s.ard = 4'd2; s.aunit = 2'd0;
    s.db = 1; s.bwb = 1; s.brd = 4'd3; s.bunit = 2'd0; apply(); settle();
    check("pre_rst_mul_mask", sb_if.mask_mul, 16'h0200);
    tick();
    s = '0; s.rst = 1; apply(); settle(); tick();
    s = '0; apply(); settle();
    check("post_rst_alu_a", sb_if.mask_alu_a, 16'h0000);
    check("post_rst_alu_b", sb_if.mask_alu_b, 16'h0000);
    check("post_rst_mul", sb_if.mask_mul, 16'h0000);
    check("post_rst_busy_mul", 16'(sb_if.busy_mul), 16'h0000);
    check("post_rst_err", 16'(sb_if.sb_err), 16'h0000);
    tick();
    s.dm = 1; apply(); settle(); tick();
    s = '0; apply(); settle();
    check("late_done_err", 16'(sb_if.sb_err), 16'h0001);
    tick();

    // Randomized traffic, with occasional resets to clear the sticky error
    s = '0; s.rst = 1; apply(); tick();
    for (int n = 0; n < 400; n++) begin
      s       = '0;
      s.rst   = ($urandom_range(0, 39) == 0);
      s.da    = 1'($urandom_range(0, 1));
      s.awb   = ($urandom_range(0, 3) != 0);
      s.ard   = 4'($urandom);
      s.aunit = 2'($urandom);
      s.db    = 1'($urandom_range(0, 1));
      s.bwb   = ($urandom_range(0, 3) != 0);
      s.brd   = 4'($urandom);
      s.bunit = 2'($urandom);
      s.dm    = m_busy[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      s.dl    = m_busy[1] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      s.dbr   = m_busy[2] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      apply(); settle(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
